// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared engine state type and derived-width helpers for ROM loaders
package rom_loader_pkg;
  typedef enum logic {IDLE, REQ} loader_state_t;
  function automatic int page_w(input int addr_w, input int slot_aw);
    return addr_w - slot_aw;
  endfunction
  function automatic int bank_w(input int banks);
    return banks > 1 ? $clog2(banks) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO (push/din in, pop in, dout/full/empty out) with one-bit-extra pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk_sys)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: ioctl byte stream in -> slot/page decode -> FIFO -> SDRAM write port (mem_*), plus busy/loaded/oob/overflow/done status
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int SLOTS_PER_BANK = 4,
  parameter int BANKS          = 2,
  parameter int SLOT_AW        = 14,
  parameter int ADDR_W         = 23,
  parameter int FIFO_DEPTH     = 4,
  parameter int INDEX          = 0,
  localparam int NSLOT  = SLOTS_PER_BANK * BANKS,
  localparam int PAGE_W = page_w(ADDR_W, SLOT_AW),
  localparam int BW     = bank_w(BANKS)
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         ce,
  input  logic                         ioctl_download,
  input  logic [7:0]                   ioctl_index,
  input  logic                         ioctl_wr,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  input  logic [SLOTS_PER_BANK*PAGE_W-1:0] page_map,
  output logic                         mem_req,
  input  logic                         mem_ack,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [BW-1:0]                mem_bank,
  output logic [7:0]                   mem_dout,
  output logic                         busy,
  output logic [NSLOT-1:0]             loaded,
  output logic                         oob,
  output logic                         overflow,
  output logic                         done
);
  localparam int SW  = NSLOT > 1 ? $clog2(NSLOT) : 1;
  localparam int SLW = 25 - SLOT_AW;
  localparam int FW  = BW + PAGE_W + SLOT_AW + 8 + 1 + SW;
  loader_state_t state;
  logic act, act_q, accept, in_range, push, pop, full, empty, drain, cur_last;
  logic [SW-1:0] cur_slot;
  logic [SLW-1:0] s;
  logic [SLOT_AW-1:0] off;
  logic [FW-1:0] din, head;
  logic [BW-1:0] h_bank;
  logic [PAGE_W-1:0] h_page;
  logic [SLOT_AW-1:0] h_off;
  logic [7:0] h_data;
  logic h_last;
  logic [SW-1:0] h_slot;
  assign act = ioctl_download && ioctl_index == 8'(INDEX);
  assign accept = act && ioctl_wr && ce;
  assign s = ioctl_addr[24:SLOT_AW];
  assign off = ioctl_addr[SLOT_AW-1:0];
  assign in_range = s < SLW'(NSLOT);
  assign push = accept && in_range && !full;
  assign din = {BW'(s / SLW'(SLOTS_PER_BANK)),
                page_map[PAGE_W*int'(s % SLW'(SLOTS_PER_BANK)) +: PAGE_W],
                off, ioctl_dout, &off, SW'(s)};
  assign {h_bank, h_page, h_off, h_data, h_last, h_slot} = head;
  assign pop = !empty && (state == IDLE || mem_ack);
  assign busy = act || !empty || mem_req;
  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys(clk_sys), .reset_n(reset_n), .push(push), .din(din),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_bank <= '0;
      mem_dout <= '0;
      cur_last <= 1'b0;
      cur_slot <= '0;
      loaded <= '0;
      oob <= 1'b0;
      overflow <= 1'b0;
      done <= 1'b0;
      act_q <= 1'b0;
      drain <= 1'b0;
    end else begin
      act_q <= act;
      done <= 1'b0;
      if (act && !act_q) begin
        loaded <= '0;
        oob <= 1'b0;
        overflow <= 1'b0;
      end
      // sets come after the start-of-download clear so they take priority
      if (accept && !in_range) oob <= 1'b1;
      if (accept && in_range && full) overflow <= 1'b1;
      if (state == REQ && mem_ack && cur_last) loaded[cur_slot] <= 1'b1;
      if (pop) begin
        state <= REQ;
        mem_req <= 1'b1;
        mem_addr <= {h_page, h_off};
        mem_bank <= h_bank;
        mem_dout <= h_data;
        cur_last <= h_last;
        cur_slot <= h_slot;
      end else if (state == REQ && mem_ack) begin
        state <= IDLE;
        mem_req <= 1'b0;
      end
      if (!act && act_q) drain <= 1'b1;
      else if (drain && empty && state == IDLE) begin
        drain <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader covering mapping, back-pressure, completion, oob, index filter/done and reset
module tb_rom_loader;
  logic clk_sys = 1'b0, reset_n, ce, ioctl_download, ioctl_wr, mem_ack;
  logic [7:0] ioctl_index, ioctl_dout, mem_dout;
  logic [24:0] ioctl_addr;
  logic [35:0] page_map;
  logic mem_req, busy, oob, overflow, done;
  logic [22:0] mem_addr;
  logic [0:0] mem_bank;
  logic [7:0] loaded;
  logic [8:0] pm [4] = '{9'h000, 9'h100, 9'h107, 9'h1ff};
  logic [31:0] q [$];
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  always #5 clk_sys = ~clk_sys;
  rom_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .page_map(page_map), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_dout(mem_dout), .busy(busy),
    .loaded(loaded), .oob(oob), .overflow(overflow), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit keep);
    int s = int'(a[24:14]);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (keep && ioctl_download && ioctl_index == 8'd0 && s < 8)
      q.push_back({1'(s / 4), pm[s % 4], a[13:0], d});
    tick();
    ioctl_wr = 1'b0;
  endtask
  task automatic start_dl();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
  endtask
  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || mem_req) && n < 100) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < 100), 1);
  endtask
  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (reset_n && mem_req && mem_ack)
      check("write", {mem_bank, mem_addr, mem_dout}, q.size() != 0 ? q.pop_front() : 32'hffff_ffff);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    page_map = {pm[3], pm[2], pm[1], pm[0]};
    reset_n = 1'b0; ce = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; mem_ack = 1'b0;
    repeat (3) tick();
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_bank", mem_bank, 0);
    check("rst_dout", mem_dout, 0);
    check("rst_flags", {loaded, oob, overflow, done, busy}, 0);
    reset_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    start_dl();
    send(25'h0000, 8'hA5, 1);
    check("lat_t", mem_req, 0);
    tick();
    check("lat_t1_req", mem_req, 1);
    check("lat_t1_data", {mem_addr, mem_dout}, {23'h0, 8'hA5});
    send(25'h4000, 8'h11, 1);
    send(25'h8000, 8'h22, 1);
    send(25'hC000, 8'h33, 1);
    send(25'h10000, 8'h44, 1);
    wait_idle();
    end_dl();
    start_dl();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("bp_no_ovf_yet", overflow, 0);
      send(25'h10 + 25'(i), 8'h60 + 8'(i), i < 5);
    end
    check("bp_overflow", overflow, 1);
    repeat (4) tick();
    mem_ack = 1'b1;
    wait_idle();
    end_dl();
    start_dl();
    check("bp_ovf_cleared", overflow, 0);
    for (int i = 0; i < 16384; i++) send(25'h8000 + 25'(i), 8'(i * 7), 1);
    check("slot_before", loaded, 0);
    tick();
    check("slot_last_issue", mem_addr, 23'h41FFFF);
    check("slot_pending", loaded, 0);
    tick();
    check("slot_loaded", loaded, 8'b0000_0100);
    wait_idle();
    end_dl();
    start_dl();
    send(25'h20000, 8'h77, 1);
    repeat (3) tick();
    check("oob_noreq", mem_req, 0);
    check("oob_set", oob, 1);
    end_dl();
    start_dl();
    check("oob_cleared", oob, 0);
    end_dl();
    repeat (4) tick();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    send(25'h0000, 8'h99, 1);
    send(25'h4000, 8'h98, 1);
    tick();
    check("idx_busy", busy, 0);
    check("idx_noreq", mem_req, 0);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick();
    mem_ack = 1'b0;
    start_dl();
    for (int i = 0; i < 4; i++) send(25'h4100 + 25'(i), 8'hC0 + 8'(i), 1);
    ioctl_download = 1'b0;
    done_cnt = 0;
    repeat (3) tick();
    check("done_held", done, 0);
    mem_ack = 1'b1;
    begin
      int n = 0;
      while (mem_req && n < 20) begin
        tick();
        n++;
      end
      check("done_drain_timeout", 64'(n < 20), 1);
    end
    check("done_at_last_ack", done, 0);
    tick();
    check("done_pulse", done, 1);
    tick();
    check("done_fall", done, 0);
    repeat (3) tick();
    check("done_count", done_cnt, 1);
    mem_ack = 1'b0;
    start_dl();
    for (int i = 0; i < 3; i++) send(25'h3FFD + 25'(i), 8'hE0 + 8'(i), 1);
    check("rst_mid_req", mem_req, 1);
    ioctl_download = 1'b0;
    reset_n = 1'b0;
    tick();
    q.delete();
    check("rst_mid_dropreq", mem_req, 0);
    check("rst_mid_empty", busy, 0);
    check("rst_mid_loaded", loaded, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst_mid_idle", {mem_req, busy}, 0);
    check("queue_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
